// File: rtl/calc_pkg.sv
// Shared widths for the calculator datapath, reused by operand entry and the result stage.
package calc_pkg;
  localparam int OP_W     = 16;
  localparam int NIBBLE_W = 4;
  localparam int DIGITS   = 4;

  function automatic logic [NIBBLE_W-1:0] nib_inc(input logic [NIBBLE_W-1:0] n);
    return n + NIBBLE_W'(1);
  endfunction
endpackage

// File: rtl/operand_entry_btn_debounce.sv
// One push-button: 2-flop synchroniser, stable-level debounce counter and rising-edge pulse.
module btn_debounce
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_q;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= btn_raw;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      // any sample matching the accepted level restarts the count
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level = r_level;
  assign press = r_level & ~r_level_q;
endmodule

// File: rtl/operand_entry.sv
// Operand entry: four debounced buttons each bump one hex digit of the operand chosen by sel.
module operand_entry
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      btn,
  input  logic            sel,
  output logic [OP_W-1:0] op1,
  output logic [OP_W-1:0] op2,
  output logic            upd
);
  logic [DIGITS-1:0] w_level;
  logic [DIGITS-1:0] w_press;
  logic [DIGITS-1:0] w_inc;
  logic [OP_W-1:0]   r_op1;
  logic [OP_W-1:0]   r_op2;
  logic              r_upd;

  for (genvar g = 0; g < DIGITS; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn[g]),
      .level  (w_level[g]),
      .press  (w_press[g])
    );
  end

  assign w_inc = w_press & w_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op1 <= '0;
      r_op2 <= '0;
      r_upd <= 1'b0;
    end else begin
      r_upd <= |w_inc;
      // each digit wraps on its own; no carry between nibbles
      for (int i = 0; i < DIGITS; i++) begin
        if (w_inc[i]) begin
          if (!sel) r_op1[i*NIBBLE_W +: NIBBLE_W] <= nib_inc(r_op1[i*NIBBLE_W +: NIBBLE_W]);
          else      r_op2[i*NIBBLE_W +: NIBBLE_W] <= nib_inc(r_op2[i*NIBBLE_W +: NIBBLE_W]);
        end
      end
    end
  end

  assign op1 = r_op1;
  assign op2 = r_op2;
  assign upd = r_upd;
endmodule

// File: doc/operand_entry.md
# operand_entry

Front-end operand entry stage for the 16-bit calculator datapath. It turns four raw push-buttons into two 16-bit hex operands, `op1` and `op2`, which feed the arithmetic/logic result stage directly. Each button is synchronised, debounced and edge-detected. A clean press increments one hex digit (nibble) of the operand chosen by `sel`.

## Interface

Reset is synchronous and active-high. The block uses one clock. The clock port is named `clk` and the reset port is named `rst`.

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive cycles a synchronised button level must hold before it is accepted (10 ms at 50 MHz). Benches override it to 4. Legal range is ≥ 1.

Ports:
- `clk`, input, 1 bit: system clock. All state changes on its rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `btn`, input, 4 bits: raw, asynchronous, bouncing push-buttons. `btn[i]` edits nibble i, so `btn[0]` edits bits 3:0.
- `sel`, input, 1 bit: selects the operand to edit. 0 selects `op1`, 1 selects `op2`. It is a quasi-static switch.
- `op1`, output, 16 bits: operand 1 register.
- `op2`, output, 16 bits: operand 2 register.
- `upd`, output, 1 bit: one-cycle pulse, high in the cycle after either operand register changes.

## Operation

- **Reset values.** `op1` = 0x0000, `op2` = 0x0000, `upd` = 0. Synchroniser flops, debounced levels and debounce counters all reset to 0.
- **Synchroniser.** Each `btn[i]` passes through a 2-flop synchroniser to give `s[i]`.
- **Debounce, per button.** Each button keeps an accepted level `d[i]` and a counter.
  - If `s[i]` equals `d[i]`, the counter clears to 0.
  - Otherwise the counter increments.
  - On the edge where the counter would reach `DEBOUNCE_CYCLES`, `d[i]` takes `s[i]` and the counter clears.
  - Any glitch back to `d[i]` restarts the count.
- **Press detect.** `p[i]` is a 1-cycle pulse on each 0→1 transition of `d[i]`. A 1→0 transition generates no action.
- **Increment.** On the edge following `p[i]`, nibble i of the selected operand becomes (nibble + 1) mod 16.
  - F wraps to 0 with no carry into nibble i+1.
  - The other operand is untouched.
- **Simultaneous presses.** All pulsing nibbles increment in the same cycle, and `upd` pulses once.
- **`sel` sampling.** `sel` is sampled at the increment edge only. Changing `sel` while a button is held has no effect until the next press.
- **Held button.** A held button produces exactly one increment. There is no auto-repeat.

## Timing

- **Press latency.** Let edge 1 be the first rising edge that samples `btn[i]` = 1 into the synchroniser. Then:
  - `d[i]` rises at edge `DEBOUNCE_CYCLES` + 2.
  - The operand nibble updates at edge `DEBOUNCE_CYCLES` + 3.
  - `upd` is high for exactly the cycle after that edge.
- **Release.** Release requires `DEBOUNCE_CYCLES` stable-low samples before a new press can be accepted.
- **Reset mid-operation.** Asserting `rst` at any point aborts any in-progress debounce with no increment and clears both operands.
  - After `rst` deasserts, a button still held counts as a fresh press.
  - Edge 1 is then the first edge with `rst` = 0.
- **Outputs.** `op1` and `op2` are registered and stable between updates. Downstream may use them combinationally.

## Structure

- **Shared package `calc_pkg`.** Holds `OP_W` = 16, `NIBBLE_W` = 4 and `DIGITS` = 4. The result stage reuses `OP_W`.
- **Sub-module `btn_debounce`.** One button's synchroniser, debounce counter and rising-edge pulse.
  - Parameter: `DEBOUNCE_CYCLES`. Counter width is $clog2(`DEBOUNCE_CYCLES` + 1).
  - Ports: `clk`, `rst`, `btn_raw`, `level`, `press`.
  - `operand_entry` instantiates it `DIGITS` times with a generate loop.
- **Top level.** Contains the nibble increment logic, the operand registers and `upd`.

## Test plan

All scenarios use `DEBOUNCE_CYCLES` = 4.

1. **Reset.** Hold `rst` for 3 cycles with arbitrary `btn`. Required: `op1` = `op2` = 0x0000 and `upd` = 0 throughout and after reset.
2. **Clean press.** `sel` = 0. Raise `btn[0]` and hold it for 20 cycles, then release. Required:
   - `op1` = 0x0001 exactly at edge 7.
   - `upd` high for one cycle.
   - No further change during the hold or on release.
3. **Bounce.** Toggle `btn[1]` every 2 cycles for 12 cycles, then hold it high. Required: exactly one increment, giving `op1` = 0x0010 and one `upd` pulse.
4. **Wrap and isolation.** `sel` = 1. Apply 16 clean presses on `btn[3]`. Required:
   - `op2` = 0xF000 after 15 presses.
   - `op2` = 0x0000 after 16 presses, with no carry.
   - `op1` unchanged.
5. **Simultaneous presses.** `sel` = 1 and `op2` = 0x0000. Press all four buttons on the same cycle. Required: `op2` = 0x1111 in a single update and exactly one `upd` pulse.
6. **Reset mid-debounce.** Hold `btn[2]` and assert `rst` when the counter reaches 2, then deassert `rst` while the button stays held. Required:
   - No increment before or during reset.
   - `op1` = 0x0100 at edge 7, counted from the first edge with `rst` = 0.
